// File: rtl/bloom_query.sv
// Bloom-filter store and query engine: insert/check/clear requests, three multiplicative hashes applied one per cycle.
// Optional BLOOM_STATS_EN adds the saturating check/hit statistics outputs chk_cnt and hit_cnt.
module bloom_query #(
  parameter int unsigned       D_SIZE  = 8,
  parameter int unsigned       BL_SIZE = 16,
  parameter logic [D_SIZE-1:0] KEY0    = 8'hA7,
  parameter logic [D_SIZE-1:0] KEY1    = 8'h3D,
  parameter logic [D_SIZE-1:0] KEY2    = 8'hE5,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [D_SIZE-1:0]  req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [BL_SIZE-1:0] bloom_vec,
  output logic [CNT_W-1:0]   insert_cnt
`ifdef BLOOM_STATS_EN
  ,
  output logic [15:0]        chk_cnt,
  output logic [15:0]        hit_cnt
`endif
);

  localparam int IDX_W = $clog2(BL_SIZE);

  typedef enum logic [1:0] {IDLE, HASH, CLEAR, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [D_SIZE-1:0]   data_q;
  logic [1:0]          h_q;
  logic                hit_acc;
  logic [D_SIZE-1:0]   key_sel;
  logic [2*D_SIZE-1:0] prod;
  logic [IDX_W-1:0]    idx;
  logic                hit_next;
  logic                accept;
  logic                is_insert;
  logic                hash_last;

  // The bit index comes from the top IDX_W bits of the double-width product for the current hash step.
  always_comb begin
    case (h_q)
      2'd0:    key_sel = KEY0;
      2'd1:    key_sel = KEY1;
      default: key_sel = KEY2;
    endcase
    prod     = {{D_SIZE{1'b0}}, key_sel} * {{D_SIZE{1'b0}}, data_q};
    idx      = prod[2*D_SIZE-1 -: IDX_W];
    hit_next = hit_acc & bloom_vec[idx];
  end

  assign accept    = (state_q == IDLE) && req_valid;
  assign is_insert = (op_q == 2'b01);
  assign hash_last = (state_q == HASH) && (h_q == 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_op == 2'b10) ? CLEAR : HASH;
      end
      HASH:  if (h_q == 2'd2) state_d = RESP;
      // Clear wipes on its first edge; the second cycle keeps the response two edges after accept.
      CLEAR: if (h_q == 2'd1) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_acc;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= 2'b00;
      data_q     <= '0;
      h_q        <= 2'd0;
      hit_acc    <= 1'b0;
      bloom_vec  <= '0;
      insert_cnt <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        data_q  <= req_data;
        h_q     <= 2'd0;
        hit_acc <= 1'b1;
      end
      if (state_q == HASH) begin
        hit_acc <= hit_next;
        h_q     <= h_q + 2'd1;
        if (is_insert) bloom_vec[idx] <= 1'b1;
        if (hash_last && is_insert && !(&insert_cnt)) insert_cnt <= insert_cnt + 1'b1;
      end
      if (state_q == CLEAR) begin
        h_q <= h_q + 2'd1;
        if (h_q == 2'd0) begin
          bloom_vec  <= '0;
          insert_cnt <= '0;
          hit_acc    <= 1'b0;
        end
      end
    end
  end

`ifdef BLOOM_STATS_EN
  // Statistics survive the clear op; only reset zeroes them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_cnt <= '0;
      hit_cnt <= '0;
    end else if (hash_last && !is_insert) begin
      if (!(&chk_cnt))            chk_cnt <= chk_cnt + 16'd1;
      if (hit_next && !(&hit_cnt)) hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bloom_query.sv
// Self-checking bench for bloom_query: directed scenarios plus randomized ops against a behavioural filter model.
// Build with BLOOM_STATS_EN defined to also exercise chk_cnt/hit_cnt.
module tb_bloom_query;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_hit;
  logic [15:0] bloom_vec;
  logic [7:0]  insert_cnt;
`ifdef BLOOM_STATS_EN
  logic [15:0] chk_cnt;
  logic [15:0] hit_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  logic [15:0] modelVec = 16'h0000;
  int modelCnt = 0;
  int modelChk = 0;
  int modelHits = 0;

  bloom_query dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .bloom_vec(bloom_vec), .insert_cnt(insert_cnt)
`ifdef BLOOM_STATS_EN
    , .chk_cnt(chk_cnt), .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hashIdx(input int key, input int d);
    return ((key * d) / 4096) % 16;
  endfunction

  task automatic checkState();
    checkOutput("bloom_vec", bloom_vec, modelVec);
    checkOutput("insert_cnt", insert_cnt, modelCnt);
`ifdef BLOOM_STATS_EN
    checkOutput("chk_cnt", chk_cnt, modelChk);
    checkOutput("hit_cnt", hit_cnt, modelHits);
`endif
  endtask

  // One complete request/response transaction, optionally stalling the response for holdCycles.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] d, input int holdCycles);
    int keys[3] = '{167, 61, 229};
    bit hit;
    int expLat;
    int lat;
    if (op == 2'b10) begin
      modelVec = 16'h0000;
      modelCnt = 0;
      hit = 1'b0;
      expLat = 2;
    end else begin
      hit = 1'b1;
      for (int k = 0; k < 3; k++) begin
        int ix;
        ix = hashIdx(keys[k], int'(d));
        hit = hit & modelVec[ix];
        if (op == 2'b01) modelVec[ix] = 1'b1;
      end
      if (op == 2'b01) begin
        if (modelCnt < 255) modelCnt++;
      end else begin
        if (modelChk < 65535) modelChk++;
        if (hit && modelHits < 65535) modelHits++;
      end
      expLat = 3;
    end

    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op = op;
    req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("rsp_hit", rsp_hit, hit);
    checkState();

    for (int i = 0; i < holdCycles; i++) begin
      req_valid = (i == 2);
      req_op = 2'b01;
      req_data = 8'h55;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("hold_rsp_valid", rsp_valid, 1);
      checkOutput("hold_rsp_hit", rsp_hit, hit);
      checkOutput("hold_req_ready", req_ready, 0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", rsp_valid, 0);
    checkOutput("req_ready_back", req_ready, 1);
    checkState();
  endtask

  initial begin
    $display("[TB] starting bloom_query bench");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bloom_vec", bloom_vec, 16'h0000);
    checkOutput("reset_insert_cnt", insert_cnt, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_hit", rsp_hit, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_req_ready", req_ready, 1);
    checkOutput("release_rsp_valid", rsp_valid, 0);

    applyStimulus(2'b01, 8'hFF, 0);
    checkOutput("insert_ff_vec", bloom_vec, 16'h4408);
    applyStimulus(2'b00, 8'hFF, 0);
    applyStimulus(2'b00, 8'h80, 0);
    checkOutput("check_keeps_vec", bloom_vec, 16'h4408);
    applyStimulus(2'b01, 8'hFF, 5);
    checkOutput("dup_insert_cnt", insert_cnt, 2);
    applyStimulus(2'b10, 8'h00, 0);
    applyStimulus(2'b01, 8'hFF, 0);
    applyStimulus(2'b00, 8'hFF, 0);
    applyStimulus(2'b11, 8'hFF, 0);
    applyStimulus(2'b00, 8'h80, 0);
    applyStimulus(2'b10, 8'h00, 0);

    // Reset in the middle of an insert (second hash step) abandons it.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b01;
    req_data = 8'h80;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    modelVec = 16'h0000;
    modelCnt = 0;
    modelChk = 0;
    modelHits = 0;
    checkOutput("midop_rsp_valid", rsp_valid, 0);
    checkState();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("after_abort_rsp_valid", rsp_valid, 0);
      checkOutput("after_abort_req_ready", req_ready, 1);
    end
    checkState();

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      applyStimulus(op, 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

    applyStimulus(2'b10, 8'h00, 0);
    for (int n = 0; n < 257; n++) applyStimulus(2'b01, 8'($urandom_range(0, 255)), 0);
    checkOutput("insert_cnt_sat", insert_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
